// File: rtl/vector_wb_arbiter.sv
// vector_wb_arbiter: buffered round-robin merge of NUM_UNITS result streams
// onto one registered VRF write port, with a pending-write hazard query.

// Per-unit result FIFO. It also reports whether any live entry targets
// query_addr with a non-zero mask. The caller gates push with !full and
// pop with !empty.
module vector_wb_arbiter_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 128,
  parameter int MW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic [MW-1:0] push_mask,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [MW-1:0] head_mask,
  output logic          full,
  output logic          empty,
  input  logic [AW-1:0] query_addr,
  output logic          hazard
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [MW-1:0]    mask_q [DEPTH];
  logic [DEPTH-1:0] slot_hit;

  // Pointers and occupancy; push+pop in one cycle leaves count unchanged.
  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage needs no reset; only slots inside count are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
      mask_q[wr_ptr] <= push_mask;
    end
  end

  // A physical slot is live when its distance from rd_ptr is below count.
  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    logic [PW-1:0] off;
    assign off         = PW'(j) - rd_ptr;
    assign slot_hit[j] = ({1'b0, off} < count) && (addr_q[j] == query_addr) && (|mask_q[j]);
  end

  assign hazard    = |slot_hit;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_mask = mask_q[rd_ptr];
endmodule

module vector_wb_arbiter #(
  parameter int NUM_UNITS           = 4,
  parameter int NUM_ELEMS           = 8,
  parameter int ELEM_SIZE           = 16,
  parameter int ENABLES_PER_ELEMENT = 4,
  parameter int VRF_SIZE            = 32,
  parameter int FIFO_DEPTH          = 2,
  parameter int AW                  = $clog2(VRF_SIZE),
  parameter int VW                  = NUM_ELEMS * ELEM_SIZE,
  parameter int MW                  = NUM_ELEMS * ENABLES_PER_ELEMENT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_UNITS-1:0]    in_valid,
  output logic [NUM_UNITS-1:0]    in_ready,
  input  logic [NUM_UNITS*VW-1:0] in_data,
  input  logic [NUM_UNITS*MW-1:0] in_mask,
  input  logic [NUM_UNITS*AW-1:0] in_addr,
  input  logic                    vrf_stall,
  output logic                    vrf_we,
  output logic [AW-1:0]           vrf_addr,
  output logic [VW-1:0]           vrf_data,
  output logic [MW-1:0]           vrf_mask,
  input  logic [AW-1:0]           query_addr,
  output logic                    query_hazard,
  output logic                    idle
);
  localparam int UW = $clog2(NUM_UNITS);

  logic [NUM_UNITS-1:0]         push, pop, full, empty, fifo_haz;
  logic [NUM_UNITS-1:0][AW-1:0] head_addr;
  logic [NUM_UNITS-1:0][VW-1:0] head_data;
  logic [NUM_UNITS-1:0][MW-1:0] head_mask;

  logic [UW-1:0] rr_ptr;
  logic [UW-1:0] grant_idx;
  logic [UW-1:0] cand_idx;
  logic          grant_vld;

  // One FIFO per producing unit; in_ready comes from registered count only.
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    assign in_ready[u] = ~full[u];
    assign push[u]     = in_valid[u] & ~full[u];
    assign pop[u]      = grant_vld & (grant_idx == UW'(u));

    vector_wb_arbiter_fifo #(
      .DEPTH(FIFO_DEPTH), .AW(AW), .DW(VW), .MW(MW)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[u]),
      .pop       (pop[u]),
      .push_addr (in_addr[u*AW +: AW]),
      .push_data (in_data[u*VW +: VW]),
      .push_mask (in_mask[u*MW +: MW]),
      .head_addr (head_addr[u]),
      .head_data (head_data[u]),
      .head_mask (head_mask[u]),
      .full      (full[u]),
      .empty     (empty[u]),
      .query_addr(query_addr),
      .hazard    (fifo_haz[u])
    );
  end

  // Round-robin pick: first non-empty FIFO after rr_ptr, none while stalled.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    if (!vrf_stall) begin
      for (int k = 1; k <= NUM_UNITS; k++) begin
        cand_idx = UW'((int'(rr_ptr) + k) % NUM_UNITS);
        if (!grant_vld && !empty[cand_idx]) begin
          grant_vld = 1'b1;
          grant_idx = cand_idx;
        end
      end
    end
  end

  // Write port register and arbitration pointer. A zero-mask grant still
  // pops, loads the fields and advances rr_ptr, but never raises vrf_we.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= UW'(NUM_UNITS - 1);
      vrf_we   <= 1'b0;
      vrf_addr <= '0;
      vrf_data <= '0;
      vrf_mask <= '0;
    end else begin
      vrf_we <= grant_vld & (|head_mask[grant_idx]);
      if (grant_vld) begin
        rr_ptr   <= grant_idx;
        vrf_addr <= head_addr[grant_idx];
        vrf_data <= head_data[grant_idx];
        vrf_mask <= head_mask[grant_idx];
      end
    end
  end

  assign query_hazard = (|fifo_haz) | (vrf_we & (vrf_addr == query_addr));
  assign idle         = (&empty) & ~vrf_we;
endmodule
